fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving queue entries and the maximum number of outstanding fetch requests (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 redirect_valid  input  1  taken branch/jump from EX (PCSrcE).
REQ-006 redirect_pc  input  32  new fetch address (PCTargetE).
REQ-007 stall  input  1  decode stage cannot accept an instruction (StallF/StallD).
REQ-008 mem_req_valid  output  1  fetch request to instruction memory.
REQ-009 mem_req_addr  output  32  word-aligned fetch address.
REQ-010 mem_req_ready  input  1  memory accepts the request this cycle.
REQ-011 mem_rsp_valid  input  1  in-order response valid, at least 1 cycle after acceptance.
REQ-012 mem_rsp_data  input  32  fetched instruction word.
REQ-013 instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-014 instr  output  32  instruction to IF/ID (InstrF).
REQ-015 instr_pc  output  32  address of instr (PCF); instr_pc+4 is PCPlus4F.

Function
REQ-016 fetch_pc register SHALL hold the next request address; mem_req_addr = fetch_pc.
REQ-017 mem_req_valid SHALL be 1 only when queued count + outstanding < DEPTH, redirect_valid = 0, and no stale responses remain to discard.
REQ-018 On mem_req_valid & mem_req_ready, fetch_pc SHALL advance by 4 (32-bit wrap: 32'hFFFF_FFFC -> 0) and the address SHALL be pushed into an internal pending-address FIFO.
REQ-019 On a non-discarded mem_rsp_valid, mem_rsp_data SHALL be enqueued with the oldest pending address and that address popped.
REQ-020 instr_valid SHALL be 1 whenever the queue is non-empty; instr/instr_pc SHALL show the head entry.
REQ-021 When the queue is empty, instr_valid SHALL be 0, instr SHALL be 32'h0000_0013 (NOP), instr_pc SHALL hold its last value.
REQ-022 The head SHALL dequeue when instr_valid & ~stall & ~redirect_valid; enqueue and dequeue in the same cycle SHALL keep count unchanged.
REQ-023 On redirect_valid: queue emptied, pending-address FIFO cleared, fetch_pc <= redirect_pc, discard counter <= outstanding minus any response arriving that cycle.
REQ-024 A response arriving while redirect_valid = 1 or discard counter > 0 SHALL be dropped; discard counter SHALL decrement per dropped response when nonzero.
REQ-025 redirect_valid SHALL take priority over stall, enqueue and dequeue in the same cycle.
REQ-026 Queue count and outstanding count SHALL never exceed DEPTH; a response with zero outstanding SHALL be ignored.

Reset
REQ-027 While reset = 0: fetch_pc = RESET_PC, queue, pending FIFO, outstanding and discard counters = 0, mem_req_valid = 0, instr_valid = 0, instr = 32'h0000_0013, instr_pc = RESET_PC.
REQ-028 Reset asserted mid-transaction SHALL abandon all outstanding requests; responses after deassertion with zero outstanding SHALL be ignored.
REQ-029 mem_req_valid SHALL first assert in the first cycle after reset deasserts.

Configuration
REQ-030 With FETCH_QUEUE_BYPASS_EN defined, a valid, non-discarded response arriving to an empty queue while stall = 0 SHALL appear on instr/instr_pc/instr_valid in the same cycle and SHALL NOT be enqueued.
REQ-031 Without FETCH_QUEUE_BYPASS_EN, every response SHALL pass through the queue, giving instr_valid one cycle after mem_rsp_valid.

Verification
REQ-032 Reset release, mem_req_ready = 1, 1-cycle response latency -> requests 0x0, 0x4, 0x8, 0xC; instr_pc sequence 0x0, 0x4, 0x8 on consecutive non-stalled cycles.
REQ-033 stall = 1 for 10 cycles, DEPTH = 4 -> at most 4 requests accepted, mem_req_valid = 0 afterwards; head instr_pc held constant.
REQ-034 redirect_valid with redirect_pc = 0x100 while 2 requests outstanding -> next 2 responses dropped, instr_valid = 0, next instr_pc = 0x100.
REQ-035 redirect and response in same cycle, 1 outstanding -> response dropped, discard counter = 0, request to redirect_pc next cycle.
REQ-036 fetch_pc = 0xFFFF_FFFC accepted -> next mem_req_addr = 0x0000_0000.
REQ-037 Build with and without FETCH_QUEUE_BYPASS_EN, empty queue, response 0x00500093 at cycle N -> instr_valid at N (bypass) or N+1 (no bypass), instr = 0x00500093.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order word fetches, buffers returned words for IF/ID,
// and squashes in-flight fetches on redirect. Define FETCH_QUEUE_BYPASS_EN for same-cycle response bypass.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic [CW-1:0] q_cnt_q, q_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [AW-1:0] q_rd_q, q_rd_d;
  logic [AW-1:0] q_wr_q, q_wr_d;
  logic [AW-1:0] pend_rd_q, pend_rd_d;
  logic [AW-1:0] pend_wr_q, pend_wr_d;

  logic [31:0]   q_data_q   [DEPTH];
  logic [31:0]   q_pc_q     [DEPTH];
  logic [31:0]   pend_addr_q[DEPTH];

  logic          q_empty;
  logic          req_fire;
  logic          rsp_take;
  logic          bypass;
  logic          enq;
  logic          deq;
  logic [SW-1:0] occupancy;
  logic [SW-1:0] in_flight;

  assign q_empty   = (q_cnt_q == '0);
  assign occupancy = SW'(q_cnt_q) + SW'(out_cnt_q);

  // No new fetch while squashing, so stale responses can never be paired with fresh addresses.
  assign mem_req_addr  = fetch_pc_q;
  assign mem_req_valid = reset && !redirect_valid && (disc_q == '0) && (occupancy < SW'(DEPTH));
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign rsp_take = mem_rsp_valid && !redirect_valid && (disc_q == '0) && (out_cnt_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = rsp_take && q_empty && !stall;
`else
  assign bypass = 1'b0;
`endif

  assign enq = rsp_take && !bypass;
  assign deq = !q_empty && !stall && !redirect_valid;

  // Head of queue, else bypassed response, else NOP with the last shown PC.
  always_comb begin : out_mux
    instr_valid = 1'b0;
    instr       = NOP_INSTR;
    instr_pc    = last_pc_q;
    if (!q_empty) begin
      instr_valid = 1'b1;
      instr       = q_data_q[q_rd_q];
      instr_pc    = q_pc_q[q_rd_q];
    end else if (bypass) begin
      instr_valid = 1'b1;
      instr       = mem_rsp_data;
      instr_pc    = pend_addr_q[pend_rd_q];
    end
  end

  always_comb begin : next_state
    fetch_pc_d = fetch_pc_q;
    last_pc_d  = instr_pc;
    q_cnt_d    = q_cnt_q;
    out_cnt_d  = out_cnt_q;
    disc_d     = disc_q;
    q_rd_d     = q_rd_q;
    q_wr_d     = q_wr_q;
    pend_rd_d  = pend_rd_q;
    pend_wr_d  = pend_wr_q;
    in_flight  = SW'(out_cnt_q) + SW'(disc_q);

    if (redirect_valid) begin
      // Everything still in flight becomes stale, minus a response landing this cycle.
      fetch_pc_d = redirect_pc;
      q_cnt_d    = '0;
      q_rd_d     = '0;
      q_wr_d     = '0;
      out_cnt_d  = '0;
      pend_rd_d  = '0;
      pend_wr_d  = '0;
      if (mem_rsp_valid && (in_flight != '0)) begin
        in_flight = in_flight - SW'(1);
      end
      disc_d = CW'(in_flight);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        pend_wr_d  = pend_wr_q + AW'(1);
      end
      if (rsp_take) begin
        pend_rd_d = pend_rd_q + AW'(1);
      end
      out_cnt_d = out_cnt_q + CW'(req_fire) - CW'(rsp_take);
      if (mem_rsp_valid && (disc_q != '0)) begin
        disc_d = disc_q - CW'(1);
      end
      if (enq) begin
        q_wr_d = q_wr_q + AW'(1);
      end
      if (deq) begin
        q_rd_d = q_rd_q + AW'(1);
      end
      q_cnt_d = q_cnt_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin : state_regs
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      last_pc_q  <= RESET_PC;
      q_cnt_q    <= '0;
      out_cnt_q  <= '0;
      disc_q     <= '0;
      q_rd_q     <= '0;
      q_wr_q     <= '0;
      pend_rd_q  <= '0;
      pend_wr_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      last_pc_q  <= last_pc_d;
      q_cnt_q    <= q_cnt_d;
      out_cnt_q  <= out_cnt_d;
      disc_q     <= disc_d;
      q_rd_q     <= q_rd_d;
      q_wr_q     <= q_wr_d;
      pend_rd_q  <= pend_rd_d;
      pend_wr_q  <= pend_wr_d;
    end
  end

  // Payload storage; validity is tracked solely by the counters and pointers above.
  always_ff @(posedge clk) begin : storage
    if (req_fire) begin
      pend_addr_q[pend_wr_q] <= fetch_pc_q;
    end
    if (enq) begin
      q_data_q[q_wr_q] <= mem_rsp_data;
      q_pc_q[q_wr_q]   <= pend_addr_q[pend_rd_q];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a queue-level model.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] acc_q[$];

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } mreq_t;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Called mid-cycle: records an accepted request, then advances to just after the next edge.
  task automatic tick();
    logic acc;
    logic [31:0] a;
    acc = mem_req_valid && mem_req_ready;
    a   = mem_req_addr;
    @(posedge clk);
    if (acc) acc_q.push_back(a);
    #1;
  endtask

  task automatic drive_rsp(input bit en);
    if (en && acc_q.size() > 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(acc_q.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    mem_req_ready = 1'b1;
    @(posedge clk); #5;
    tests_run++;
    if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); end
    tests_run++;
    if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    tests_run++;
    if (instr !== NOP) begin tests_failed++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
    tests_run++;
    if (instr_pc !== RESET_PC) begin tests_failed++; $display("FAIL reset_instr_pc: got %h want %h", instr_pc, RESET_PC); end
    @(posedge clk); #1 reset = 1'b1;
    #4;
    tests_run++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin
      tests_failed++; $display("FAIL first_req: got valid=%b addr=%h want 1 %h", mem_req_valid, mem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] epc;
    do_reset();
    mem_req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_rsp(k >= 1);
      #4;
      if (k < 4) begin
        tests_run++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'(4 * k)) begin
          tests_failed++; $display("FAIL seq_req%0d: got valid=%b addr=%h want 1 %h", k, mem_req_valid, mem_req_addr, 32'(4 * k));
        end
      end
      if (k >= 2 - BYP) begin
        epc = 32'(4 * (k - 2 + BYP));
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== epc || instr !== mem_word(epc)) begin
          tests_failed++; $display("FAIL seq_instr%0d: got v=%b pc=%h i=%h want 1 %h %h", k, instr_valid, instr_pc, instr, epc, mem_word(epc));
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int accepts;
    do_reset();
    mem_req_ready = 1'b1;
    stall = 1'b1;
    accepts = 0;
    for (int k = 0; k < 10; k++) begin
      drive_rsp(1'b1);
      #4;
      if (mem_req_valid && mem_req_ready) accepts++;
      if (k >= 2) begin
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
          tests_failed++; $display("FAIL stall_hold%0d: got v=%b pc=%h want 1 00000000", k, instr_valid, instr_pc);
        end
      end
      tick();
    end
    drive_rsp(1'b0);
    #4;
    tests_run++;
    if (accepts !== 4) begin tests_failed++; $display("FAIL stall_accepts: got %0d want 4", accepts); end
    tests_run++;
    if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_req_off: got %b want 0", mem_req_valid); end
    tick();
    stall = 1'b0;
    mem_req_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #4;
      tests_run++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * j) || instr !== mem_word(32'(4 * j))) begin
        tests_failed++; $display("FAIL drain%0d: got v=%b pc=%h i=%h want 1 %h", j, instr_valid, instr_pc, instr, 32'(4 * j));
      end
      tick();
    end
    #4;
    tests_run++;
    if (instr_valid !== 1'b0 || instr !== NOP || instr_pc !== 32'hC) begin
      tests_failed++; $display("FAIL empty_hold: got v=%b pc=%h i=%h want 0 0000000c %h", instr_valid, instr_pc, instr, NOP);
    end
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    mem_req_ready = 1'b1;
    #4; tick();
    #4; tick();
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    drive_rsp(1'b0);
    #4;
    tests_run++;
    if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_req_off: got %b want 0", mem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      drive_rsp(1'b1);
      #4;
      tests_run++;
      if (mem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
        tests_failed++; $display("FAIL redir_drop%0d: got req=%b iv=%b want 0 0", j, mem_req_valid, instr_valid);
      end
      tick();
    end
    drive_rsp(1'b0);
    mem_req_ready = 1'b1;
    #4;
    tests_run++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin
      tests_failed++; $display("FAIL redir_req: got valid=%b addr=%h want 1 00000100", mem_req_valid, mem_req_addr);
    end
    tick();
    mem_req_ready = 1'b0;
    drive_rsp(1'b1);
    if (BYP == 0) begin #4; tick(); mem_rsp_valid = 1'b0; end
    #4;
    tests_run++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem_word(32'h100)) begin
      tests_failed++; $display("FAIL redir_instr: got v=%b pc=%h i=%h want 1 00000100 %h", instr_valid, instr_pc, instr, mem_word(32'h100));
    end
    tick();
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    mem_req_ready = 1'b1;
    #4; tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    drive_rsp(1'b1);
    #4;
    tests_run++;
    if (mem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL same_drop: got req=%b iv=%b want 0 0", mem_req_valid, instr_valid);
    end
    tick();
    redirect_valid = 1'b0;
    drive_rsp(1'b0);
    #4;
    tests_run++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL same_req: got valid=%b addr=%h iv=%b want 1 00000200 0", mem_req_valid, mem_req_addr, instr_valid);
    end
    tick();
    mem_req_ready = 1'b0;
    drive_rsp(1'b1);
    if (BYP == 0) begin #4; tick(); mem_rsp_valid = 1'b0; end
    #4;
    tests_run++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== mem_word(32'h200)) begin
      tests_failed++; $display("FAIL same_instr: got v=%b pc=%h i=%h want 1 00000200", instr_valid, instr_pc, instr);
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #4; tick();
    redirect_valid = 1'b0;
    mem_req_ready = 1'b1;
    #4;
    tests_run++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'hFFFF_FFFC) begin
      tests_failed++; $display("FAIL wrap_req0: got valid=%b addr=%h want 1 fffffffc", mem_req_valid, mem_req_addr);
    end
    tick();
    mem_req_ready = 1'b0;
    #4;
    tests_run++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
      tests_failed++; $display("FAIL wrap_req1: got valid=%b addr=%h want 1 00000000", mem_req_valid, mem_req_addr);
    end
    tick();
    drive_rsp(1'b1);
    if (BYP == 0) begin #4; tick(); mem_rsp_valid = 1'b0; end
    #4;
    tests_run++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr !== mem_word(32'hFFFF_FFFC)) begin
      tests_failed++; $display("FAIL wrap_instr: got v=%b pc=%h i=%h want 1 fffffffc", instr_valid, instr_pc, instr);
    end
    tick();
  endtask

  task automatic test_latency();
    logic [31:0] w;
    do_reset();
    mem_req_ready = 1'b1;
    #4; tick();
    mem_req_ready = 1'b0;
    w = acc_q.pop_front();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0050_0093;
    #4;
    tests_run++;
    if (instr_valid !== 1'(BYP) || instr !== ((BYP != 0) ? 32'h0050_0093 : NOP) || instr_pc !== w) begin
      tests_failed++; $display("FAIL lat_cycle_n: got v=%b i=%h pc=%h want %0d", instr_valid, instr, instr_pc, BYP);
    end
    tick();
    mem_rsp_valid = 1'b0;
    #4;
    tests_run++;
    if (instr_valid !== 1'(1 - BYP) || instr !== ((BYP != 0) ? NOP : 32'h0050_0093) || instr_pc !== w) begin
      tests_failed++; $display("FAIL lat_cycle_n1: got v=%b i=%h pc=%h want %0d", instr_valid, instr, instr_pc, 1 - BYP);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_req_ready = 1'b1;
    #4; tick();
    #4; tick();
    reset = 1'b0;
    #2;
    tests_run++;
    if (mem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr_pc !== RESET_PC) begin
      tests_failed++; $display("FAIL midrst_idle: got req=%b iv=%b pc=%h want 0 0 %h", mem_req_valid, instr_valid, instr_pc, RESET_PC);
    end
    acc_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    #4;
    tests_run++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_first: got req=%b addr=%h iv=%b want 1 %h 0", mem_req_valid, mem_req_addr, instr_valid, RESET_PC);
    end
    tick();
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    #4;
    tests_run++;
    if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_stray: got iv=%b want 0", instr_valid); end
    tick();
    mem_req_ready = 1'b0;
    drive_rsp(1'b1);
    if (BYP == 0) begin #4; tick(); mem_rsp_valid = 1'b0; end
    #4;
    tests_run++;
    if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr !== mem_word(RESET_PC)) begin
      tests_failed++; $display("FAIL midrst_instr: got v=%b pc=%h i=%h want 1 %h %h", instr_valid, instr_pc, instr, RESET_PC, mem_word(RESET_PC));
    end
    tick();
  endtask

  task automatic test_random();
    mreq_t       memq[$];
    mreq_t       e;
    logic [31:0] iq[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_last_pc;
    int          cyc;
    do_reset();
    m_fetch_pc = RESET_PC;
    m_last_pc  = RESET_PC;
    cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      logic redir, stl, rdy, rsp, stale_any, exp_rv, good, byp, exp_iv;
      logic [31:0] r, rpc, exp_pc, exp_instr;
      int nonstale;
      r     = $urandom;
      redir = ($urandom_range(0, 99) < 4);
      rpc   = (r[1:0] == 2'b00) ? 32'hFFFF_FFF4 : {r[31:2], 2'b00};
      stl   = ($urandom_range(0, 99) < 30);
      rdy   = ($urandom_range(0, 99) < 70);
      rsp   = (memq.size() > 0) && (memq[0].due <= cyc) && ($urandom_range(0, 99) < 65);
      stale_any = 1'b0;
      nonstale  = 0;
      foreach (memq[i]) begin
        if (memq[i].stale) stale_any = 1'b1;
        else nonstale++;
      end
      exp_rv    = !redir && !stale_any && (iq.size() + nonstale < DEPTH);
      good      = rsp && !memq[0].stale && !redir;
      byp       = (BYP != 0) && good && (iq.size() == 0) && !stl;
      exp_iv    = (iq.size() > 0) || byp;
      exp_pc    = (iq.size() > 0) ? iq[0] : (byp ? memq[0].addr : m_last_pc);
      exp_instr = exp_iv ? mem_word(exp_pc) : NOP;

      redirect_valid = redir;
      redirect_pc    = rpc;
      stall          = stl;
      mem_req_ready  = rdy;
      mem_rsp_valid  = rsp;
      mem_rsp_data   = rsp ? mem_word(memq[0].addr) : 32'h0;
      #4;
      tests_run++;
      if (mem_req_valid !== exp_rv) begin tests_failed++; $display("FAIL rnd_req_valid@%0d: got %b want %b", n, mem_req_valid, exp_rv); end
      tests_run++;
      if (mem_req_addr !== m_fetch_pc) begin tests_failed++; $display("FAIL rnd_req_addr@%0d: got %h want %h", n, mem_req_addr, m_fetch_pc); end
      tests_run++;
      if (instr_valid !== exp_iv) begin tests_failed++; $display("FAIL rnd_instr_valid@%0d: got %b want %b", n, instr_valid, exp_iv); end
      tests_run++;
      if (instr_pc !== exp_pc) begin tests_failed++; $display("FAIL rnd_instr_pc@%0d: got %h want %h", n, instr_pc, exp_pc); end
      tests_run++;
      if (instr !== exp_instr) begin tests_failed++; $display("FAIL rnd_instr@%0d: got %h want %h", n, instr, exp_instr); end

      e = '{addr: 32'h0, stale: 1'b0, due: 0};
      if (rsp) e = memq.pop_front();
      if (redir) begin
        iq.delete();
        foreach (memq[i]) memq[i].stale = 1'b1;
        m_fetch_pc = rpc;
      end else begin
        if (iq.size() > 0 && !stl) void'(iq.pop_front());
        if (good && !byp) iq.push_back(e.addr);
        if (exp_rv && rdy) begin
          memq.push_back('{addr: m_fetch_pc, stale: 1'b0, due: cyc + 1 + int'($urandom_range(0, 2))});
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end
      m_last_pc = exp_pc;
      @(posedge clk);
      cyc++;
      #1;
    end
    idle_inputs();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_same_cycle();
    test_wrap();
    test_latency();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
